// File: rtl/vga2_rect_sequencer_pkg.sv
// Shared VGA2 definitions: instruction opcodes, sequencer FSM states and
// the instruction word packer used by the rectangle sequencer.
package vga2_rect_sequencer_pkg;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDR = 4'd1;
   localparam logic [3:0] OP_LDC = 4'd2;
   localparam logic [3:0] OP_LDD = 4'd3;
   localparam logic [3:0] OP_LDI = 4'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LDR,
      ST_LDC,
      ST_LDD,
      ST_LDI
   } state_t;

   function automatic logic [11:0] mk_inst(input logic [3:0] op, input logic [7:0] imm);
      return {op, imm};
   endfunction

endpackage

// File: rtl/vga2_rect_sequencer_if.sv
// Command port plus VGA2 instruction port of the rectangle sequencer.
// The host side is the master, the sequencer is the slave.
interface vga2_rect_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_row;
   logic [7:0]  cmd_col;
   logic [7:0]  cmd_h;
   logic [7:0]  cmd_w;
   logic [3:0]  cmd_color;
   logic        cmd_abort;
   logic        done;
   logic        err;
   logic [11:0] inst;
   logic        inst_en;

   modport master (
      output cmd_valid, cmd_row, cmd_col, cmd_h, cmd_w, cmd_color, cmd_abort,
      input  cmd_ready, done, err, inst, inst_en
   );

   modport slave (
      input  cmd_valid, cmd_row, cmd_col, cmd_h, cmd_w, cmd_color, cmd_abort,
      output cmd_ready, done, err, inst, inst_en
   );
endinterface

// File: rtl/vga2_rect_sequencer.sv
// Rectangle-fill command to VGA2 instruction stream converter: range-checks a
// command, then emits LDR/LDC/LDD/LDI per row, one instruction per cycle.
module vga2_rect_sequencer
   import vga2_rect_sequencer_pkg::*;
#(
   parameter int FbCols = 200,
   parameter int FbRows = 150
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   vga2_rect_sequencer_if.slave  io_bus
);

   state_t      r_state;
   logic [7:0]  r_row;
   logic [7:0]  r_last_row;
   logic [7:0]  r_col;
   logic [7:0]  r_w_m1;
   logic [7:0]  r_cnt;
   logic [3:0]  r_color;
   logic        r_pend_done;
   logic        r_pend_err;
   logic        r_cmd_ready;
   logic        r_done;
   logic        r_err;
   logic [11:0] r_inst;
   logic        r_inst_en;

   logic [8:0]  w_col_end;
   logic [8:0]  w_row_end;
   logic        w_reject;
   logic        w_zero;
   logic        w_accept;
   logic        w_busy;
   logic        w_row_done;
   logic        w_last_row;

   // 9-bit sums so an oversized command cannot alias back into range
   assign w_col_end  = {1'b0, io_bus.cmd_col} + {1'b0, io_bus.cmd_w};
   assign w_row_end  = {1'b0, io_bus.cmd_row} + {1'b0, io_bus.cmd_h};
   assign w_reject   = (w_col_end > 9'(FbCols)) || (w_row_end > 9'(FbRows));
   assign w_zero     = (io_bus.cmd_w == 8'd0) || (io_bus.cmd_h == 8'd0);
   assign w_busy     = (r_state != ST_IDLE);
   assign w_accept   = io_bus.cmd_valid & r_cmd_ready & ~io_bus.cmd_abort & ~w_busy;
   assign w_row_done = ((r_state == ST_LDD) && (r_w_m1 == 8'd0)) ||
                       ((r_state == ST_LDI) && (r_cnt == 8'd1));
   assign w_last_row = (r_row == r_last_row);

   assign io_bus.cmd_ready = r_cmd_ready;
   assign io_bus.done      = r_done;
   assign io_bus.err       = r_err;
   assign io_bus.inst      = r_inst;
   assign io_bus.inst_en   = r_inst_en;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_row       <= 8'd0;
         r_last_row  <= 8'd0;
         r_col       <= 8'd0;
         r_w_m1      <= 8'd0;
         r_cnt       <= 8'd0;
         r_color     <= 4'd0;
         r_pend_done <= 1'b0;
         r_pend_err  <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_inst      <= 12'h000;
         r_inst_en   <= 1'b0;
      end else begin
         r_inst      <= mk_inst(OP_NOP, 8'h00);
         r_inst_en   <= 1'b0;
         // done/err are delayed one cycle so they land after the last instruction
         r_done      <= r_pend_done;
         r_err       <= r_pend_err;
         r_pend_done <= 1'b0;
         r_pend_err  <= 1'b0;
         if (w_busy && io_bus.cmd_abort) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_cmd_ready <= 1'b1;
                  if (w_accept) begin
                     if (w_reject) begin
                        r_pend_err <= 1'b1;
                     end else if (w_zero) begin
                        r_pend_done <= 1'b1;
                     end else begin
                        r_row       <= io_bus.cmd_row;
                        r_last_row  <= io_bus.cmd_row + io_bus.cmd_h - 8'd1;
                        r_col       <= io_bus.cmd_col;
                        r_w_m1      <= io_bus.cmd_w - 8'd1;
                        r_color     <= io_bus.cmd_color;
                        r_state     <= ST_LDR;
                        r_cmd_ready <= 1'b0;
                     end
                  end
               end
               ST_LDR: begin
                  r_inst    <= mk_inst(OP_LDR, r_row);
                  r_inst_en <= 1'b1;
                  r_state   <= ST_LDC;
               end
               ST_LDC: begin
                  r_inst    <= mk_inst(OP_LDC, r_col);
                  r_inst_en <= 1'b1;
                  r_state   <= ST_LDD;
               end
               ST_LDD: begin
                  r_inst    <= mk_inst(OP_LDD, {4'h0, r_color});
                  r_inst_en <= 1'b1;
                  r_cnt     <= r_w_m1;
                  r_state   <= ST_LDI;
               end
               ST_LDI: begin
                  r_inst    <= mk_inst(OP_LDI, {4'h0, r_color});
                  r_inst_en <= 1'b1;
                  r_cnt     <= r_cnt - 8'd1;
               end
               default: r_state <= ST_IDLE;
            endcase
            // End of row overrides the per-state next state chosen above
            if (w_row_done) begin
               if (w_last_row) begin
                  r_state     <= ST_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_pend_done <= 1'b1;
               end else begin
                  r_row   <= r_row + 8'd1;
                  r_state <= ST_LDR;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vga2_rect_sequencer.sv
// Directed bench for vga2_rect_sequencer: hand-computed instruction streams,
// pulse timing, range rejection, abort and asynchronous reset.
module tb_vga2_rect_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga2_rect_sequencer_if bus ();

   vga2_rect_sequencer #(.FbCols(200), .FbRows(150)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Collector: sampled on the falling edge, away from the active edge
   logic [11:0] q_inst[$];
   int          q_cyc[$];
   int          n_done = 0;
   int          n_err = 0;
   int          n_bad = 0;
   int          done_cyc = -1;
   int          err_cyc = -1;
   always @(negedge clk) begin
      if (bus.inst_en === 1'b1) begin
         q_inst.push_back(bus.inst);
         q_cyc.push_back(cyc);
      end else if (bus.inst !== 12'h000) begin
         n_bad <= n_bad + 1;
      end
      if (bus.done === 1'b1) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (bus.err === 1'b1) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int acc_cyc;
   int base_i;
   int base_d;
   int base_e;

   task automatic issue(input logic [7:0] row, input logic [7:0] col, input logic [7:0] h,
                        input logic [7:0] w, input logic [3:0] color);
      int k;
      bus.cmd_row   = row;
      bus.cmd_col   = col;
      bus.cmd_h     = h;
      bus.cmd_w     = w;
      bus.cmd_color = color;
      bus.cmd_valid = 1'b1;
      base_i = q_inst.size();
      base_d = n_done;
      base_e = n_err;
      for (k = 0; k < 50; k++) begin
         if (bus.cmd_ready === 1'b1) break;
         tick();
      end
      if (k == 50) check("ready_timeout", 32'(k), 32'd0);
      tick();
      acc_cyc = cyc;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_end(input int limit);
      int k;
      for (k = 0; k < limit; k++) begin
         if (n_done != base_d || n_err != base_e) break;
         tick();
      end
      if (k == limit) check("end_timeout", 32'(k), 32'd0);
      tick();
      tick();
   endtask

   logic [11:0] exp2[10];
   int          n;

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_abort = 1'b0;
      bus.cmd_row   = 8'd0;
      bus.cmd_col   = 8'd0;
      bus.cmd_h     = 8'd0;
      bus.cmd_w     = 8'd0;
      bus.cmd_color = 4'd0;
      #1;
      check("rst_ready", bus.cmd_ready, 0);
      check("rst_inst_en", bus.inst_en, 0);
      check("rst_inst", bus.inst, 12'h000);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("ready_after_rst", bus.cmd_ready, 1);

      // 1x1 rectangle, cycle by cycle
      issue(8'd5, 8'd10, 8'd1, 8'd1, 4'hA);
      check("t1_ready_busy", bus.cmd_ready, 0);
      check("t1_no_inst_at_N", bus.inst_en, 0);
      tick();
      check("t1_inst0", {bus.inst_en, bus.inst}, {1'b1, 12'h105});
      tick();
      check("t1_inst1", {bus.inst_en, bus.inst}, {1'b1, 12'h20A});
      tick();
      check("t1_inst2", {bus.inst_en, bus.inst}, {1'b1, 12'h30A});
      check("t1_no_early_done", bus.done, 0);
      tick();
      check("t1_done", bus.done, 1);
      check("t1_en_off", {bus.inst_en, bus.inst}, 13'h0000);
      check("t1_ready_back", bus.cmd_ready, 1);
      tick();
      check("t1_done_1cyc", bus.done, 0);

      // 2x3 rectangle
      exp2[0] = 12'h100; exp2[1] = 12'h200; exp2[2] = 12'h307; exp2[3] = 12'h407;
      exp2[4] = 12'h407; exp2[5] = 12'h101; exp2[6] = 12'h200; exp2[7] = 12'h307;
      exp2[8] = 12'h407; exp2[9] = 12'h407;
      issue(8'd0, 8'd0, 8'd2, 8'd3, 4'h7);
      wait_end(100);
      n = q_inst.size() - base_i;
      check("t2_count", 32'(n), 32'd10);
      for (int i = 0; i < 10; i++)
         if (base_i + i < q_inst.size()) check($sformatf("t2_inst%0d", i), q_inst[base_i + i], exp2[i]);
      check("t2_done_cnt", 32'(n_done - base_d), 32'd1);
      check("t2_first_lat", 32'(q_cyc[base_i]), 32'(acc_cyc + 1));
      check("t2_done_lat", 32'(done_cyc), 32'(q_cyc[q_cyc.size() - 1] + 1));

      // out-of-range column
      issue(8'd0, 8'd190, 8'd1, 8'd11, 4'h3);
      check("t3_ready_rej", bus.cmd_ready, 1);
      tick();
      check("t3_err", bus.err, 1);
      tick();
      check("t3_err_1cyc", bus.err, 0);
      tick();
      check("t3_err_lat", 32'(err_cyc), 32'(acc_cyc + 1));
      check("t3_no_inst", 32'(q_inst.size() - base_i), 32'd0);
      check("t3_no_done", 32'(n_done - base_d), 32'd0);

      // exactly at the column limit
      issue(8'd0, 8'd190, 8'd1, 8'd10, 4'hC);
      wait_end(100);
      check("t3b_count", 32'(q_inst.size() - base_i), 32'd12);
      check("t3b_ldc", q_inst[base_i + 1], 12'h2BE);
      check("t3b_last", q_inst[q_inst.size() - 1], 12'h40C);
      check("t3b_err", 32'(n_err - base_e), 32'd0);

      // zero-size, in range
      issue(8'd0, 8'd0, 8'd4, 8'd0, 4'h5);
      tick();
      check("t4_done", bus.done, 1);
      check("t4_ready", bus.cmd_ready, 1);
      tick();
      tick();
      check("t4_done_lat", 32'(done_cyc), 32'(acc_cyc + 1));
      check("t4_no_inst", 32'(q_inst.size() - base_i), 32'd0);

      // full-width bottom row
      issue(8'd149, 8'd0, 8'd1, 8'd200, 4'h4);
      wait_end(400);
      check("t4b_count", 32'(q_inst.size() - base_i), 32'd202);
      check("t4b_ldr", q_inst[base_i], 12'h195);
      check("t4b_last", q_inst[q_inst.size() - 1], 12'h404);
      check("t4b_done_lat", 32'(done_cyc), 32'(q_cyc[q_cyc.size() - 1] + 1));

      // abort while idle beats a simultaneous command
      base_i = q_inst.size();
      base_d = n_done;
      bus.cmd_row = 8'd1; bus.cmd_col = 8'd1; bus.cmd_h = 8'd1; bus.cmd_w = 8'd1;
      bus.cmd_valid = 1'b1;
      bus.cmd_abort = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_abort = 1'b0;
      tick();
      tick();
      check("idle_abort_ready", bus.cmd_ready, 1);
      check("idle_abort_no_inst", 32'(q_inst.size() - base_i), 32'd0);
      check("idle_abort_no_done", 32'(n_done - base_d), 32'd0);

      // abort during the first LDI of the second row
      issue(8'd2, 8'd3, 8'd3, 8'd5, 4'h9);
      repeat (11) tick();
      check("t5_busy_ready", bus.cmd_ready, 0);
      bus.cmd_abort = 1'b1;
      tick();
      bus.cmd_abort = 1'b0;
      check("t5_en_drop", bus.inst_en, 0);
      check("t5_done", bus.done, 1);
      check("t5_ready", bus.cmd_ready, 1);
      tick();
      tick();
      check("t5_count", 32'(q_inst.size() - base_i), 32'd11);
      check("t5_last", q_inst[q_inst.size() - 1], 12'h409);
      check("t5_done_cnt", 32'(n_done - base_d), 32'd1);
      issue(8'd5, 8'd10, 8'd1, 8'd1, 4'hA);
      wait_end(50);
      check("t5_next_count", 32'(q_inst.size() - base_i), 32'd3);
      check("t5_next_ldr", q_inst[base_i], 12'h105);

      // asynchronous reset mid-row
      issue(8'd0, 8'd0, 8'd2, 8'd5, 4'h1);
      repeat (3) tick();
      check("t6_running", bus.inst_en, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_en_clear", bus.inst_en, 0);
      check("t6_inst_clear", bus.inst, 12'h000);
      check("t6_ready_clear", bus.cmd_ready, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      base_d = n_done;
      base_e = n_err;
      tick();
      check("t6_ready_back", bus.cmd_ready, 1);
      repeat (3) tick();
      check("t6_no_done", 32'(n_done - base_d), 32'd0);
      check("t6_no_err", 32'(n_err - base_e), 32'd0);
      check("inst_zero_when_idle", 32'(n_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
